data_req_ctrl: RTL and testbench

DATA_REQ_CTRL -- requirements
Module: data_req_ctrl

---
 rtl/data_req_ctrl.sv | 170 +++++++++++++++++
 tb/tb_data_req_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_req_ctrl.sv
// MEM-stage to SRAM-like data bus request controller with flush-driven silent completion.
// Optional DATA_REQ_PIPE_EN: allow a second request to issue while the first is still outstanding.
module data_req_ctrl (
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_req_valid,
    input  logic        ms_req_ex,
    input  logic        ms_req_wr,
    input  logic [2:0]  ms_req_size,
    input  logic [3:0]  ms_req_wstrb,
    input  logic [31:0] ms_req_addr,
    input  logic [31:0] ms_req_wdata,
    output logic        ms_req_ready,

    input  logic        flush,
    output logic        ms_resp_valid,
    output logic [31:0] ms_resp_rdata,

    output logic        data_req,
    output logic        data_wr,
    output logic [2:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 3;
    localparam int unsigned BW    = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned DEPTH = 2;

`ifdef DATA_REQ_PIPE_EN
    localparam logic PIPE_EN = 1'b1;
`else
    localparam logic PIPE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          wr_q;
    logic [SW-1:0] size_q;
    logic [BW-1:0] wstrb_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic             req_cancel_q, req_cancel_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] cancel_q, cancel_d;

    logic accept;
    logic issue;
    logic push;
    logic pop;

    // Acceptance window: IDLE always, WAIT only when pipelining has a free slot.
    always_comb begin
        ms_req_ready = 1'b0;
        if (!reset && !flush) begin
            case (state_q)
                IDLE:    ms_req_ready = 1'b1;
                WAIT:    ms_req_ready = PIPE_EN && (count_q < CW'(DEPTH));
                default: ms_req_ready = 1'b0;
            endcase
        end
    end

    assign accept = ms_req_valid & ms_req_ready;
    assign issue  = accept & ~ms_req_ex;
    assign push   = (state_q == REQ) & data_addr_ok;
    assign pop    = data_data_ok & (count_q != CW'(0));

    assign ms_resp_valid = pop & ~cancel_q[0] & ~flush;
    assign ms_resp_rdata = data_rdata;

    assign data_req   = (state_q == REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_wstrb = wstrb_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

    // Outstanding tracker: entry 0 is oldest; pop shifts, flush marks live entries, push appends.
    always_comb begin
        cancel_d     = cancel_q;
        count_d      = count_q;
        req_cancel_d = req_cancel_q;

        if (pop) begin
            cancel_d = {1'b0, cancel_q[1]};
            count_d  = count_q - CW'(1);
        end

        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CW'(i) < count_d) cancel_d[i] = 1'b1;
            end
            if (state_q == REQ) req_cancel_d = 1'b1;
        end

        if (push) begin
            cancel_d[count_d[0]] = req_cancel_q | flush;
            count_d              = count_d + CW'(1);
            req_cancel_d         = 1'b0;
        end

        if (issue) req_cancel_d = 1'b0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue) state_d = REQ;
            end
            REQ: begin
                if (data_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (issue)                      state_d = REQ;
                else if (count_d == CW'(0))     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            cancel_q     <= '0;
            req_cancel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cancel_q     <= cancel_d;
            req_cancel_q <= req_cancel_d;
        end
    end

    // Bus fields latched on issue and held through the REQ handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            size_q  <= '0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (issue) begin
            wr_q    <= ms_req_wr;
            size_q  <= ms_req_size;
            wstrb_q <= ms_req_wstrb;
            addr_q  <= ms_req_addr;
            wdata_q <= ms_req_wdata;
        end
    end

endmodule

// File: tb/tb_data_req_ctrl.sv
// Directed bench for data_req_ctrl: scripted bus handshakes, queue-based response scoreboard.
module tb_data_req_ctrl;

    logic        clk;
    logic        reset;
    logic        ms_req_valid;
    logic        ms_req_ex;
    logic        ms_req_wr;
    logic [2:0]  ms_req_size;
    logic [3:0]  ms_req_wstrb;
    logic [31:0] ms_req_addr;
    logic [31:0] ms_req_wdata;
    logic        ms_req_ready;
    logic        flush;
    logic        ms_resp_valid;
    logic [31:0] ms_resp_rdata;
    logic        data_req;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    data_req_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .ms_req_valid  (ms_req_valid),
        .ms_req_ex     (ms_req_ex),
        .ms_req_wr     (ms_req_wr),
        .ms_req_size   (ms_req_size),
        .ms_req_wstrb  (ms_req_wstrb),
        .ms_req_addr   (ms_req_addr),
        .ms_req_wdata  (ms_req_wdata),
        .ms_req_ready  (ms_req_ready),
        .flush         (flush),
        .ms_resp_valid (ms_resp_valid),
        .ms_resp_rdata (ms_resp_rdata),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_wstrb    (data_wstrb),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive point: just after the rising edge; checks follow at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic offer(input logic wr, input logic [2:0] size, input logic [3:0] wstrb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ms_req_valid = 1'b1;
        ms_req_wr    = wr;
        ms_req_size  = size;
        ms_req_wstrb = wstrb;
        ms_req_addr  = addr;
        ms_req_wdata = wdata;
    endtask

    // Response monitor: every ms_resp_valid must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && ms_resp_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL resp_unexpected: got %h expected no response at %0t", ms_resp_rdata, $time);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (ms_resp_rdata !== e) begin
                        miscompares++;
                        $display("FAIL resp_data: got %h expected %h at %0t", ms_resp_rdata, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        ms_req_valid = 1'b1;
        ms_req_ex    = 1'b0;
        ms_req_wr    = 1'b0;
        ms_req_size  = 3'd2;
        ms_req_wstrb = 4'h0;
        ms_req_addr  = 32'h0;
        ms_req_wdata = 32'h0;
        flush        = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;

        // Reset
        step(); mid();
        chk("rst_ready", 32'(ms_req_ready), 32'h0);
        step(); mid();
        chk("rst_ready2", 32'(ms_req_ready), 32'h0);
        chk("rst_data_req", 32'(data_req), 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_resp_valid", 32'(ms_resp_valid), 32'h0);
        step();
        reset = 1'b0;
        ms_req_valid = 1'b0;
        mid();
        chk("idle_ready", 32'(ms_req_ready), 32'h1);

        // Load word at 0x1000: addr_ok cycle 1, data_ok cycle 3
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_1000, 32'h0); mid();
        chk("ld_accept_ready", 32'(ms_req_ready), 32'h1);
        step(); ms_req_valid = 1'b0; data_addr_ok = 1'b1; mid();
        chk("ld_c1_data_req", 32'(data_req), 32'h1);
        chk("ld_c1_addr", data_addr, 32'h0000_1000);
        chk("ld_c1_wr", 32'(data_wr), 32'h0);
        chk("ld_c1_size", 32'(data_size), 32'h2);
        step(); data_addr_ok = 1'b0; mid();
        chk("ld_c2_data_req", 32'(data_req), 32'h0);
`ifndef DATA_REQ_PIPE_EN
        chk("ld_c2_wait_ready", 32'(ms_req_ready), 32'h0);
`endif
        step(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; exp_q.push_back(32'hDEAD_BEEF); mid();
        chk("ld_c3_resp_valid", 32'(ms_resp_valid), 32'h1);
        step(); data_data_ok = 1'b0; data_rdata = 32'h0; mid();
        chk("ld_c4_idle_ready", 32'(ms_req_ready), 32'h1);
        chk("ld_c4_resp_valid", 32'(ms_resp_valid), 32'h0);

        // Store byte, wstrb 0x4, addr_ok after 5 cycles; MEM side keeps offering junk
        step(); offer(1'b1, 3'd0, 4'h4, 32'h0000_2002, 32'h00AB_0000); mid();
        for (int i = 0; i < 6; i++) begin
            step();
            offer(1'b0, 3'd2, 4'hF, 32'hFFFF_FFF0, 32'h1234_5678);
            data_addr_ok = (i == 5);
            mid();
            chk("st_data_req", 32'(data_req), 32'h1);
            chk("st_wr", 32'(data_wr), 32'h1);
            chk("st_size", 32'(data_size), 32'h0);
            chk("st_wstrb", 32'(data_wstrb), 32'h4);
            chk("st_addr", data_addr, 32'h0000_2002);
            chk("st_wdata", data_wdata, 32'h00AB_0000);
            chk("st_ready", 32'(ms_req_ready), 32'h0);
        end
        step(); ms_req_valid = 1'b0; data_addr_ok = 1'b0; mid();
        step(); data_data_ok = 1'b1; data_rdata = 32'h0; exp_q.push_back(32'h0); mid();
        chk("st_resp_valid", 32'(ms_resp_valid), 32'h1);
        step(); data_data_ok = 1'b0; mid();
        chk("st_idle_ready", 32'(ms_req_ready), 32'h1);

        // Flush while in REQ: request held, completion silent
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_3000, 32'h0); mid();
        step(); ms_req_valid = 1'b0; flush = 1'b1; mid();
        chk("fl_req_held0", 32'(data_req), 32'h1);
        chk("fl_ready", 32'(ms_req_ready), 32'h0);
        step(); flush = 1'b0; mid();
        chk("fl_req_held1", 32'(data_req), 32'h1);
        chk("fl_addr_held", data_addr, 32'h0000_3000);
        step(); data_addr_ok = 1'b1; mid();
        chk("fl_req_held2", 32'(data_req), 32'h1);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555; mid();
        chk("fl_resp_silent", 32'(ms_resp_valid), 32'h0);
        step(); data_data_ok = 1'b0; mid();
        chk("fl_idle_ready", 32'(ms_req_ready), 32'h1);

        // Flush and data_ok in the same cycle
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_4000, 32'h0); mid();
        step(); ms_req_valid = 1'b0; data_addr_ok = 1'b1; mid();
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; flush = 1'b1; data_rdata = 32'h6666_6666; mid();
        chk("fd_resp_valid", 32'(ms_resp_valid), 32'h0);
        chk("fd_ready", 32'(ms_req_ready), 32'h0);
        step(); data_data_ok = 1'b0; flush = 1'b0; mid();
        chk("fd_idle_ready", 32'(ms_req_ready), 32'h1);

        // Exception op consumed without a bus request
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_4001, 32'h0); ms_req_ex = 1'b1; mid();
        chk("ex_ready", 32'(ms_req_ready), 32'h1);
        step(); ms_req_valid = 1'b0; ms_req_ex = 1'b0; mid();
        chk("ex_no_req0", 32'(data_req), 32'h0);
        step(); mid();
        chk("ex_no_req1", 32'(data_req), 32'h0);
        chk("ex_idle_ready", 32'(ms_req_ready), 32'h1);

        // Flush in IDLE blocks acceptance for that cycle only
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_4100, 32'h0); flush = 1'b1; mid();
        chk("fi_ready", 32'(ms_req_ready), 32'h0);
        step(); ms_req_valid = 1'b0; flush = 1'b0; mid();
        chk("fi_no_req", 32'(data_req), 32'h0);
        chk("fi_ready_back", 32'(ms_req_ready), 32'h1);

        // Stray handshakes in IDLE are ignored
        step(); data_data_ok = 1'b1; data_addr_ok = 1'b1; data_rdata = 32'h7777_7777; mid();
        chk("stray_resp", 32'(ms_resp_valid), 32'h0);
        step(); data_data_ok = 1'b0; data_addr_ok = 1'b0; mid();
        chk("stray_no_req", 32'(data_req), 32'h0);
        chk("stray_ready", 32'(ms_req_ready), 32'h1);

`ifdef DATA_REQ_PIPE_EN
        // Two back-to-back loads, third held off while two are outstanding
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_5000, 32'h0); mid();
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_5004, 32'h0); data_addr_ok = 1'b1; mid();
        chk("pp_a_req", 32'(data_req), 32'h1);
        chk("pp_a_ready", 32'(ms_req_ready), 32'h0);
        step(); data_addr_ok = 1'b0; exp_q.push_back(32'h11); exp_q.push_back(32'h22); mid();
        chk("pp_b_ready", 32'(ms_req_ready), 32'h1);
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_5008, 32'h0); data_addr_ok = 1'b1; mid();
        chk("pp_b_req", 32'(data_req), 32'h1);
        chk("pp_b_addr", data_addr, 32'h0000_5004);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h11; mid();
        chk("pp_full_ready", 32'(ms_req_ready), 32'h0);
        chk("pp_r1_valid", 32'(ms_resp_valid), 32'h1);
        step(); ms_req_valid = 1'b0; data_rdata = 32'h22; mid();
        chk("pp_r2_valid", 32'(ms_resp_valid), 32'h1);
        step(); data_data_ok = 1'b0; mid();
        chk("pp_idle_ready", 32'(ms_req_ready), 32'h1);
        chk("pp_no_third", 32'(data_req), 32'h0);
`endif

        // Reset mid-transaction abandons everything
        step(); offer(1'b0, 3'd2, 4'h0, 32'h0000_6000, 32'h0); mid();
        step(); ms_req_valid = 1'b0; reset = 1'b1; mid();
        chk("mr_req_before", 32'(data_req), 32'h1);
        chk("mr_ready", 32'(ms_req_ready), 32'h0);
        step(); reset = 1'b0; mid();
        chk("mr_data_req", 32'(data_req), 32'h0);
        chk("mr_addr", data_addr, 32'h0);
        chk("mr_ready_back", 32'(ms_req_ready), 32'h1);
        step(); data_data_ok = 1'b1; data_rdata = 32'h8888_8888; mid();
        chk("mr_resp_ignored", 32'(ms_resp_valid), 32'h0);
        step(); data_data_ok = 1'b0; mid();

        step(); step();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
